// File: rtl/collision_scheduler.sv
// collision_scheduler
//
// Time-multiplexes a single point-in-box comparator across every projectile
// slot once per frame. P1 projectiles (slots 0..NUM_PROJ-1) are tested
// against the P2 body box; P2 projectiles (slots NUM_PROJ..S-1) against the
// P1 body box. All positions are snapshotted when the scan is accepted, so
// inputs may change freely while the scan runs.
//
// Optional build macro: COLLISION_SKIP_INACTIVE_EN
//   defined   - only active slots are visited, in ascending order
//               (scan length = popcount of snapshot proj_active, min 1)
//   undefined - fixed S-cycle scan over every slot
//
// Ports:
//   Clk, Reset_n           clock, asynchronous active-low reset
//   start                  one-cycle scan request (ignored unless idle)
//   proj_x, proj_y         packed 10-bit positions, slot k at [10k+9:10k]
//   proj_active            per-slot live flag
//   p1_x/p1_y, p2_x/p2_y   hitbox top-left corners
//   busy                   high while scanning
//   done                   one-cycle pulse on the final evaluation edge
//   hit_valid              one-cycle pulse per hit; hit_idx/hit_tgt qualify it
//   hit_tgt                0 = P1 was hit, 1 = P2 was hit
//   hit_mask               slots that hit during the last scan
//   hit_cnt_p1/hit_cnt_p2  hits taken by each player during the last scan
module collision_scheduler #(
    parameter  int NUM_PROJ = 4,
    parameter  int TGT_W    = 64,
    parameter  int TGT_H    = 96,
    parameter  int CW       = $clog2(NUM_PROJ + 1),
    localparam int S        = 2 * NUM_PROJ,
    localparam int IW       = $clog2(S)
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            start,
    input  logic [10*S-1:0] proj_x,
    input  logic [10*S-1:0] proj_y,
    input  logic [S-1:0]    proj_active,
    input  logic [9:0]      p1_x,
    input  logic [9:0]      p1_y,
    input  logic [9:0]      p2_x,
    input  logic [9:0]      p2_y,
    output logic            busy,
    output logic            done,
    output logic            hit_valid,
    output logic [IW-1:0]   hit_idx,
    output logic            hit_tgt,
    output logic [S-1:0]    hit_mask,
    output logic [CW-1:0]   hit_cnt_p1,
    output logic [CW-1:0]   hit_cnt_p2
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t state, state_nx;

    // Frame snapshot
    logic [S-1:0][9:0] snap_x, snap_y;
    logic [S-1:0]      snap_act;
    logic [9:0]        snap_p1x, snap_p1y, snap_p2x, snap_p2y;

    logic [IW-1:0] idx, idx_nx, idx_first;
    logic          last;

    // Comparator for the slot currently addressed by idx
    logic [9:0] ox, oy, tx, ty;
    logic       tgt_p2, contact, hit_now;

    always_comb begin
        ox     = snap_x[idx];
        oy     = snap_y[idx];
        tgt_p2 = (idx < IW'(NUM_PROJ));
        tx     = tgt_p2 ? snap_p2x : snap_p1x;
        ty     = tgt_p2 ? snap_p2y : snap_p1y;
        // Far edges are formed 11 bits wide so a box near x/y=1023 does not
        // wrap around to the left/top of the field.
        contact = ({1'b0, ox} >= {1'b0, tx}) &&
                  ({1'b0, ox} <  ({1'b0, tx} + 11'(TGT_W))) &&
                  ({1'b0, oy} >= {1'b0, ty}) &&
                  ({1'b0, oy} <  ({1'b0, ty} + 11'(TGT_H)));
        hit_now = snap_act[idx] && contact;
    end

`ifdef COLLISION_SKIP_INACTIVE_EN
    // Slot ordering: jump straight between active slots. The downward loops
    // leave the lowest qualifying index in place.
    always_comb begin
        idx_first = '0;
        for (int i = S - 1; i >= 0; i--)
            if (proj_active[i]) idx_first = IW'(i);
        idx_nx = idx;
        last   = 1'b1;
        for (int i = S - 1; i >= 0; i--)
            if ((i > int'(idx)) && snap_act[i]) begin
                idx_nx = IW'(i);
                last   = 1'b0;
            end
    end
`else
    // Slot ordering: every slot, 0..S-1.
    always_comb begin
        idx_first = '0;
        idx_nx    = idx + 1'b1;
        last      = (idx == IW'(S - 1));
    end
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = SCAN;
            SCAN: if (last)  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            snap_x     <= '0;
            snap_y     <= '0;
            snap_act   <= '0;
            snap_p1x   <= '0;
            snap_p1y   <= '0;
            snap_p2x   <= '0;
            snap_p2y   <= '0;
            idx        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            hit_valid  <= 1'b0;
            hit_idx    <= '0;
            hit_tgt    <= 1'b0;
            hit_mask   <= '0;
            hit_cnt_p1 <= '0;
            hit_cnt_p2 <= '0;
        end else begin
            done      <= 1'b0;
            hit_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        snap_x     <= proj_x;
                        snap_y     <= proj_y;
                        snap_act   <= proj_active;
                        snap_p1x   <= p1_x;
                        snap_p1y   <= p1_y;
                        snap_p2x   <= p2_x;
                        snap_p2y   <= p2_y;
                        hit_mask   <= '0;
                        hit_cnt_p1 <= '0;
                        hit_cnt_p2 <= '0;
                        idx        <= idx_first;
                        busy       <= 1'b1;
                    end
                end
                SCAN: begin
                    if (hit_now) begin
                        hit_valid     <= 1'b1;
                        hit_idx       <= idx;
                        hit_tgt       <= tgt_p2;
                        hit_mask[idx] <= 1'b1;
                        // At most NUM_PROJ hits per player, so CW never overflows.
                        if (tgt_p2) hit_cnt_p2 <= hit_cnt_p2 + 1'b1;
                        else        hit_cnt_p1 <= hit_cnt_p1 + 1'b1;
                    end
                    idx <= idx_nx;
                    if (last) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/collision_scheduler.md
Name: collision_scheduler

Overview:
- Time-multiplexes one point-in-box comparator across every live projectile once per frame.
- P1 projectiles are checked against the P2 body box; P2 projectiles are checked against the P1 body box.
- Sits between the projectile/player position registers and the game-state logic (health, projectile despawn). Started once per frame by a one-cycle pulse derived from the frame clock.

Parameters:
- NUM_PROJ, 4, projectile slots per player; total slots S = 2*NUM_PROJ. Slots 0..NUM_PROJ-1 belong to P1, slots NUM_PROJ..S-1 belong to P2.
- TGT_W, 64, player hitbox width in pixels.
- TGT_H, 96, player hitbox height in pixels.
- CW, $clog2(NUM_PROJ+1), hit-counter width.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle scan request.
- proj_x  in  10*S  projectile X positions; slot k occupies bits [10k+9:10k].
- proj_y  in  10*S  projectile Y positions; same packing as proj_x.
- proj_active  in  S  per-slot live flag.
- p1_x, p1_y  in  10 each  P1 hitbox top-left corner.
- p2_x, p2_y  in  10 each  P2 hitbox top-left corner.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse when the scan completes.
- hit_valid  out  1  one-cycle pulse per detected hit.
- hit_idx  out  $clog2(S)  slot index of the current hit.
- hit_tgt  out  1  hit target: 0 = P1 was hit, 1 = P2 was hit.
- hit_mask  out  S  slots that hit during the last scan.
- hit_cnt_p1, hit_cnt_p2  out  CW each  hits taken by each player in the last scan.

Behaviour:
- Reset (async, Reset_n=0): state IDLE; busy, done, hit_valid, hit_idx, hit_tgt, hit_mask and both counters all 0; snapshot registers 0.
- States: IDLE and SCAN.
- IDLE, start=1 at edge E0:
  - snapshot all position inputs and proj_active;
  - clear hit_mask and both counters;
  - idx=0, busy=1, go to SCAN.
- SCAN, at edge E(k+1): evaluate slot k from the snapshot only.
  - Target for slot k: P2 if k<NUM_PROJ, else P1.
  - Contact when ox>=tx, ox<tx+TGT_W, oy>=ty and oy<ty+TGT_H.
  - Sums are computed 11 bits wide; there is no 10-bit wrap.
  - If active and contact: hit_valid=1, hit_idx=k, hit_tgt set, hit_mask[k]=1, and the matching counter increments.
  - Otherwise hit_valid=0.
- Last slot at edge E(S): evaluated as above; in the same edge done=1, busy=0, go to IDLE.
- Latency: done, and any hit for slot S-1, are visible after E(S). The hit for slot k is visible after E(k+1).
- done and hit_valid are pulses: cleared on the following edge.
- hit_idx and hit_tgt hold their last value when hit_valid=0.
- hit_mask and both counters stay stable from done until the next accepted start.
- start while busy: ignored; no restart and no effect on the scan.
- start coinciding with the done edge: ignored. A new scan is accepted from IDLE on the next cycle.
- Input changes during SCAN have no effect on the scan.
- Counters cannot overflow: at most NUM_PROJ hits per player per scan.
- Reset asserted mid-scan: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: COLLISION_SKIP_INACTIVE_EN.
- Defined: the scan visits only active slots in ascending order.
  - At E0, idx loads the lowest active slot.
  - Each evaluation edge advances idx to the next higher active slot.
  - The edge that evaluates the highest active slot raises done.
  - With no active slots at start: done pulses after E1, with no hits.
  - Scan length equals the popcount of the snapshot proj_active, minimum 1 cycle.
- Undefined: fixed S-cycle scan exactly as described under Behaviour.

Test Plan:
- Reset: hold Reset_n=0 with random inputs -> every output is 0. Release, no start -> outputs remain 0.
- Idle scan (NUM_PROJ=4), all slots inactive, start pulse -> busy high for 8 cycles, done after E8, no hit_valid, hit_mask=8'h00, both counters 0.
- Single hit: P2 at (100,100), slot 1 active at (110,150), start -> hit_valid after E2 with hit_idx=1, hit_tgt=1. Then hit_mask=8'h02, hit_cnt_p2=1, hit_cnt_p1=0.
- Edge cases with P2 at (100,100):
  - proj at (164,150) -> no hit (right edge exclusive);
  - proj at (100,100) -> hit;
  - proj at (163,195) -> hit.
- Wrap cases: P2 at (1000,100), proj at (10,150) -> no hit; proj at (1020,150) -> hit.
- Robustness:
  - second start pulse at E3 -> ignored, done still after E8;
  - move slot 5 into P1's box during the scan -> no hit reported;
  - Reset_n low at E4 -> outputs zero, no done;
  - with COLLISION_SKIP_INACTIVE_EN and only slots 2 and 6 active -> done after E2.
